interrupt_sequencer: RTL and testbench

INTERRUPT_SEQUENCER -- requirements
Module: interrupt_sequencer

---
 rtl/interrupt_sequencer.sv | 146 ++++++++++++++
 tb/tb_interrupt_sequencer.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/interrupt_sequencer.sv
// interrupt_sequencer
//   Injects fixed instruction words into decode to perform interrupt entry
//   (push PC low/high, push CCR, load vector) and return-from-interrupt
//   (pop PC low/high, pop CCR). The pipeline is stalled while a sequence runs.
//
//   Build option: define ISR_DRAIN_EN to append NOP_CYCLES drain NOPs after
//   each sequence. With it undefined, both sequences return straight to IDLE
//   and NOP_CYCLES is only range-checked.
//
//   Outputs are registered copies of the decode of the next state, so they
//   always equal a pure function of the current state register (Moore).
module interrupt_sequencer #(
   parameter int OP_WIDTH   = 16,
   parameter int NOP_CYCLES = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                int_req,
   input  logic                rti,
   output logic [OP_WIDTH-1:0] out,
   output logic                inject_valid,
   output logic                stall,
   output logic                int_ack,
   output logic                busy
);

   typedef enum logic [3:0] {
      IDLE,
      PUSH_PC_LOW,
      PUSH_PC_HIGH,
      PUSH_CCR,
      LOAD_VECTOR,
      POP_PC_LOW,
      POP_PC_HIGH,
      POP_CCR
`ifdef ISR_DRAIN_EN
      , DRAIN
`endif
   } state_t;

   if (NOP_CYCLES < 1 || NOP_CYCLES > 15) begin : g_bad_nop_cycles
      $error("interrupt_sequencer: NOP_CYCLES must be in 1..15");
   end

   state_t state;
   state_t state_nx;
   logic   int_pending;
   logic   int_pending_nx;

`ifdef ISR_DRAIN_EN
   localparam logic [3:0] DRAIN_LOAD = 4'(NOP_CYCLES - 1);

   logic [3:0] drain_cnt;
   logic [3:0] drain_cnt_nx;
`endif

   // Instruction word injected for a given state.
   function automatic logic [OP_WIDTH-1:0] op_of(input state_t s);
      logic [OP_WIDTH-1:0] op;
      op = '0;
      case (s)
         PUSH_PC_LOW:  op = OP_WIDTH'(16'h5088);
         PUSH_PC_HIGH: op = OP_WIDTH'(16'h5089);
         PUSH_CCR:     op = OP_WIDTH'(16'hFFFE);
         LOAD_VECTOR:  op = OP_WIDTH'(16'hFFFD);
         POP_PC_LOW:   op = OP_WIDTH'(16'h6088);
         POP_PC_HIGH:  op = OP_WIDTH'(16'h6089);
         POP_CCR:      op = OP_WIDTH'(16'hFFFF);
         default:      op = '0;
      endcase
      return op;
   endfunction

   // Next-state, drain counter and pending-interrupt logic.
   always_comb begin
      state_nx = state;
`ifdef ISR_DRAIN_EN
      drain_cnt_nx = drain_cnt;
`endif
      case (state)
         IDLE: begin
            // rti wins a tie; the interrupt is left pending for afterwards
            if (rti)
               state_nx = POP_PC_LOW;
            else if (int_req || int_pending)
               state_nx = PUSH_PC_LOW;
         end
         PUSH_PC_LOW:  state_nx = PUSH_PC_HIGH;
         PUSH_PC_HIGH: state_nx = PUSH_CCR;
         PUSH_CCR:     state_nx = LOAD_VECTOR;
         POP_PC_LOW:   state_nx = POP_PC_HIGH;
         POP_PC_HIGH:  state_nx = POP_CCR;
`ifdef ISR_DRAIN_EN
         LOAD_VECTOR, POP_CCR: begin
            state_nx     = DRAIN;
            drain_cnt_nx = DRAIN_LOAD;
         end
         DRAIN: begin
            if (drain_cnt == 4'd0)
               state_nx = IDLE;
            else
               drain_cnt_nx = drain_cnt - 4'd1;
         end
`else
         LOAD_VECTOR, POP_CCR: state_nx = IDLE;
`endif
         default: state_nx = IDLE;
      endcase

      // entry acknowledges the pending request; otherwise any int_req latches
      if (state_nx == PUSH_PC_LOW)
         int_pending_nx = 1'b0;
      else if (int_req)
         int_pending_nx = 1'b1;
      else
         int_pending_nx = int_pending;
   end

   // State, counter and registered Moore outputs; reset aborts any sequence.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= IDLE;
         int_pending  <= 1'b0;
`ifdef ISR_DRAIN_EN
         drain_cnt    <= '0;
`endif
         out          <= '0;
         inject_valid <= 1'b0;
         stall        <= 1'b0;
         busy         <= 1'b0;
         int_ack      <= 1'b0;
      end else begin
         state        <= state_nx;
         int_pending  <= int_pending_nx;
`ifdef ISR_DRAIN_EN
         drain_cnt    <= drain_cnt_nx;
`endif
         out          <= op_of(state_nx);
         inject_valid <= (state_nx != IDLE);
         stall        <= (state_nx != IDLE);
         busy         <= (state_nx != IDLE);
         int_ack      <= (state_nx == PUSH_PC_LOW);
      end
   end

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Directed bench for interrupt_sequencer. Expected drain length follows
// ISR_DRAIN_EN as defined for the build (NOP_CYCLES fixed at 4).
module tb_interrupt_sequencer;

`ifdef ISR_DRAIN_EN
   localparam int unsigned DRAIN_N = 4;
`else
   localparam int unsigned DRAIN_N = 0;
`endif

   logic        clk;
   logic        reset;
   logic        int_req;
   logic        rti;
   logic [15:0] out;
   logic        inject_valid;
   logic        stall;
   logic        int_ack;
   logic        busy;

   int unsigned vectors;
   int unsigned miscompares;

   interrupt_sequencer #(
      .OP_WIDTH   (16),
      .NOP_CYCLES (4)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .int_req      (int_req),
      .rti          (rti),
      .out          (out),
      .inject_valid (inject_valid),
      .stall        (stall),
      .int_ack      (int_ack),
      .busy         (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] e_out,
                      input logic e_v, input logic e_ack);
      logic [19:0] obs;
      logic [19:0] exp;
      obs = {out, inject_valid, stall, busy, int_ack};
      exp = {e_out, e_v, e_v, e_v, e_ack};
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed {out,iv,stall,busy,ack}=%h expected %h", tag, obs, exp);
      end
   endtask

   // Checks a whole sequence starting at its first injected cycle and ends
   // on the IDLE cycle after it. Optionally drives rti/int_req for one cycle
   // while the sequence is at index poke_idx.
   task automatic play(input string tag, input bit entry, input int unsigned poke_idx,
                       input bit p_rti, input bit p_int);
      logic [15:0] ops [4];
      int unsigned n;
      if (entry) begin
         ops = '{16'h5088, 16'h5089, 16'hFFFE, 16'hFFFD};
         n   = 4;
      end else begin
         ops = '{16'h6088, 16'h6089, 16'hFFFF, 16'h0000};
         n   = 3;
      end
      for (int unsigned i = 0; i < n + DRAIN_N; i++) begin
         chk(tag, (i < n) ? ops[i] : 16'h0000, 1'b1, entry && (i == 0));
         if (i == poke_idx) begin
            rti     = p_rti;
            int_req = p_int;
         end
         step();
         rti     = 1'b0;
         int_req = 1'b0;
      end
      chk({tag, " idle"}, 16'h0000, 1'b0, 1'b0);
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      reset       = 1'b0;
      rti         = 1'b0;
      int_req     = 1'b0;

      // reset state, with a request present while held in reset
      step();
      chk("reset", 16'h0000, 1'b0, 1'b0);
      int_req = 1'b1;
      step();
      chk("reset hold", 16'h0000, 1'b0, 1'b0);
      int_req = 1'b0;
      reset   = 1'b1;
      step();
      chk("post release", 16'h0000, 1'b0, 1'b0);
      step();
      chk("post release 2", 16'h0000, 1'b0, 1'b0);

      // return sequence
      rti = 1'b1;
      step();
      rti = 1'b0;
      play("rti", 1'b0, 99, 1'b0, 1'b0);
      step();
      chk("rti quiet", 16'h0000, 1'b0, 1'b0);

      // entry sequence from a one-cycle request
      int_req = 1'b1;
      step();
      int_req = 1'b0;
      play("int", 1'b1, 99, 1'b0, 1'b0);
      step();
      chk("int quiet", 16'h0000, 1'b0, 1'b0);

      // rti and int_req together: return first, entry after one IDLE cycle
      rti     = 1'b1;
      int_req = 1'b1;
      step();
      rti     = 1'b0;
      int_req = 1'b0;
      play("both ret", 1'b0, 99, 1'b0, 1'b0);
      step();
      play("both entry", 1'b1, 99, 1'b0, 1'b0);
      step();
      chk("both quiet", 16'h0000, 1'b0, 1'b0);

      // rti while busy with entry is dropped
      int_req = 1'b1;
      step();
      int_req = 1'b0;
      play("rti ignored", 1'b1, 1, 1'b1, 1'b0);
      step();
      chk("rti ignored quiet", 16'h0000, 1'b0, 1'b0);
      step();
      chk("rti ignored quiet 2", 16'h0000, 1'b0, 1'b0);

      // int_req during a return sequence is kept and served back-to-back
      rti = 1'b1;
      step();
      rti = 1'b0;
      play("ret int", 1'b0, 1, 1'b0, 1'b1);
      step();
      play("pending entry", 1'b1, 99, 1'b0, 1'b0);
      step();
      chk("pending quiet", 16'h0000, 1'b0, 1'b0);

      // asynchronous reset in PUSH_CCR with a request pending
      int_req = 1'b1;
      step();
      int_req = 1'b0;
      chk("abort ppl", 16'h5088, 1'b1, 1'b1);
      int_req = 1'b1;
      step();
      int_req = 1'b0;
      chk("abort pph", 16'h5089, 1'b1, 1'b0);
      step();
      chk("abort ccr", 16'hFFFE, 1'b1, 1'b0);
      reset = 1'b0;
      #1;
      chk("async reset", 16'h0000, 1'b0, 1'b0);
      step();
      chk("async reset held", 16'h0000, 1'b0, 1'b0);
      reset = 1'b1;
      for (int unsigned k = 0; k < 6; k++) begin
         step();
         chk("after abort", 16'h0000, 1'b0, 1'b0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
